uart_tx_sched: RTL and testbench

//  Transmit scheduler between the CPU store path and the uart module. It queues bytes from

---
 rtl/uart_tx_sched_pkg.sv | 19 +
 rtl/uart_tx_sched_tx_byte_fifo.sv | 64 ++++++
 rtl/uart_tx_sched.sv | 105 ++++++++++
 tb/tb_uart_tx_sched.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_tx_sched_pkg;

  // Scheduler FSM: IDLE waits for a queued byte, GAP paces one byte time.
  typedef enum logic {
    TXS_IDLE = 1'b0,
    TXS_GAP  = 1'b1
  } txs_state_e;

  localparam int          UART_TX_DEPTH    = 16;
  localparam int          UART_BYTE_CYCLES = 868;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h0000_0804;

  // Level field in the status word is 4 bits wide; clamp instead of wrapping.
  function automatic logic [3:0] status_level(input logic [31:0] lvl);
    return (lvl > 32'd15) ? 4'hF : lvl[3:0];
  endfunction

endpackage

// File: rtl/uart_tx_sched_tx_byte_fifo.sv
// Byte FIFO with flush; read data is combinational from the head entry.
module tx_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [7:0]       head_data,
  output logic [PTR_W:0]   level,
  output logic             full,
  output logic             empty
);

  logic [7:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             push_ok;
  logic             pop_ok;

  // Flush beats a push; a full queue refuses pushes even if a pop happens now.
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty;

  // Next pointer/level values; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    level_d  = level_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  // Control state; only this is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign full      = (level_q == (PTR_W+1)'(DEPTH));
  assign empty     = (level_q == '0);

endmodule

// File: rtl/uart_tx_sched.sv
// Paces queued CPU store bytes into the uart, one byte per BYTE_CYCLES clocks.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int DEPTH       = UART_TX_DEPTH,
  parameter int PTR_W       = 4,
  parameter int BYTE_CYCLES = UART_BYTE_CYCLES
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [7:0]     wr_data,
  input  logic           flush,
  output logic           uart_wr_o,
  output logic [7:0]     uart_dat_o,
  output logic           full,
  output logic           empty,
  output logic           busy,
  output logic [31:0]    status_word,
  output logic [PTR_W:0] level
);

  localparam int CNT_W = $clog2(BYTE_CYCLES);

  txs_state_e       state_q, state_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             overflow_q, overflow_d;
  logic             wr_q, wr_d;
  logic [7:0]       dat_q, dat_d;
  logic             pop;
  logic [7:0]       head_data;

  tx_byte_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .flush     (flush),
    .head_data (head_data),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  // Next-state: launch a byte when one is queued and the previous byte time has elapsed.
  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    wr_d       = 1'b0;
    dat_d      = dat_q;
    pop        = 1'b0;
    overflow_d = overflow_q | (wr_en & full & ~flush);
    case (state_q)
      TXS_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          dat_d     = head_data;
          wr_d      = 1'b1;
          gap_cnt_d = CNT_W'(BYTE_CYCLES - 1);
          state_d   = TXS_GAP;
        end
      end
      TXS_GAP: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end else if (!empty) begin
          pop       = 1'b1;
          dat_d     = head_data;
          wr_d      = 1'b1;
          gap_cnt_d = CNT_W'(BYTE_CYCLES - 1);
        end else begin
          state_d = TXS_IDLE;
        end
      end
      default: state_d = TXS_IDLE;
    endcase
  end

  // State and output registers; reset abandons any gap in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TXS_IDLE;
      gap_cnt_q  <= '0;
      overflow_q <= 1'b0;
      wr_q       <= 1'b0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      overflow_q <= overflow_d;
      wr_q       <= wr_d;
      dat_q      <= dat_d;
    end
  end

  assign uart_wr_o   = wr_q;
  assign uart_dat_o  = dat_q;
  assign busy        = (state_q != TXS_IDLE) || !empty;
  assign status_word = {25'b0, overflow_q, busy, full, empty, status_level(32'(level))};

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched with a queue-based reference model.
module tb_uart_tx_sched;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int BC    = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_en;
  logic [7:0]     wr_data;
  logic           flush;
  logic           uart_wr_o;
  logic [7:0]     uart_dat_o;
  logic           full;
  logic           empty;
  logic           busy;
  logic [31:0]    status_word;
  logic [PTR_W:0] level;

  always #5 clk = ~clk;

  uart_tx_sched #(
    .DEPTH       (DEPTH),
    .PTR_W       (PTR_W),
    .BYTE_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .flush       (flush),
    .uart_wr_o   (uart_wr_o),
    .uart_dat_o  (uart_dat_o),
    .full        (full),
    .empty       (empty),
    .busy        (busy),
    .status_word (status_word),
    .level       (level)
  );

  typedef struct {
    logic [7:0] b;
    int         t;
  } exp_t;

  int         total = 0;
  int         bad   = 0;
  int         t     = 0;
  bit         started = 1'b0;
  logic [7:0] mq[$];
  exp_t       expq[$];
  bit         m_ovf;
  int         m_last;
  logic [7:0] m_dat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%h want=%h", name, t, act, exp);
    end
  endtask

  // Model: a byte launches whenever one is queued and BC edges have passed since the last launch.
  task automatic model_edge(input bit r, input bit w, input bit f, input logic [7:0] d);
    int lvl;
    bit was_full;
    if (r) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_last = -1;
      m_dat  = 8'h00;
    end else begin
      lvl      = mq.size();
      was_full = (lvl == DEPTH);
      if (lvl > 0 && (m_last < 0 || t - m_last >= BC)) begin
        m_dat  = mq.pop_front();
        m_last = t;
        expq.push_back('{m_dat, t});
      end
      if (f) mq.delete();
      else if (w) begin
        if (was_full) m_ovf = 1'b1;
        else mq.push_back(d);
      end
    end
  endtask

  task automatic cyc(input bit r, input bit w, input bit f, input logic [7:0] d);
    @(negedge clk);
    rst = r; wr_en = w; flush = f; wr_data = d;
    @(posedge clk);
    t++;
    model_edge(r, w, f, d);
    started = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Monitor: pulses are matched against the scoreboard; levels against the model.
  always @(negedge clk) begin
    if (started) begin
      int  lvl;
      bit  m_busy;
      exp_t e;
      lvl    = mq.size();
      m_busy = (m_last >= 0 && t - m_last < BC) || (lvl > 0);
      if (uart_wr_o === 1'b1) begin
        if (expq.size() == 0) chk("spurious_pulse", 32'(uart_wr_o), 32'd0);
        else begin
          e = expq.pop_front();
          chk("pulse_edge", t, e.t);
          chk("pulse_data", 32'(uart_dat_o), 32'(e.b));
        end
      end else if (expq.size() > 0 && expq[0].t <= t) begin
        chk("missing_pulse", 32'(uart_wr_o), 32'd1);
        void'(expq.pop_front());
      end
      chk("dat_hold", 32'(uart_dat_o), 32'(m_dat));
      chk("level", 32'(level), lvl);
      chk("full", 32'(full), 32'(lvl == DEPTH));
      chk("empty", 32'(empty), 32'(lvl == 0));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("status", status_word,
          {25'b0, m_ovf, m_busy, (lvl == DEPTH), (lvl == 0), (lvl > 15) ? 4'hF : 4'(lvl)});
    end
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; flush = 1'b0; wr_data = 8'h00;
    m_ovf = 1'b0; m_last = -1; m_dat = 8'h00;

    // Reset held for 3 clocks
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("reset_status", status_word, 32'h0000_0010);

    // Single byte
    cyc(1'b0, 1'b1, 1'b0, 8'h41);
    idle(14);

    // Burst of four
    for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, 1'b0, 8'(i));
    idle(36);

    // Overflow: six back-to-back pushes
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 8'h50 + 8'(i));
    idle(45);

    // Flush together with a push during GAP
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 8'h60 + 8'(i));
    idle(2);
    cyc(1'b0, 1'b1, 1'b1, 8'h6F);
    idle(20);

    // Reset in the middle of a gap, then a fresh push
    cyc(1'b0, 1'b1, 1'b0, 8'h70);
    cyc(1'b0, 1'b1, 1'b0, 8'h71);
    idle(4);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h72);
    idle(12);

    // Randomized traffic with varying push density
    for (int seg = 0; seg < 12; seg++) begin
      int dens;
      dens = int'($urandom_range(1, 9));
      for (int i = 0; i < 150; i++) begin
        cyc(($urandom_range(0, 399) == 0),
            ($urandom_range(0, 9) < dens),
            ($urandom_range(0, 79) == 0),
            8'($urandom));
      end
    end

    idle(BC * (DEPTH + 2));
    @(negedge clk);
    chk("scoreboard_drained", expq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
